mem_access_stage: RTL
=====================

# mem_access_stage

Combinational-plus-FSM memory stage of the 5-stage MIPS32 pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It performs loads and stores against a handshaked data memory, with byte, halfword and word sizes and alignment checking. It holds the pipeline with `me_stall` while memory is slow, and presents either a completed result or a bubble to the MEM/WB register every cycle.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of WAIT cycles before a bus error is declared (legal range 2–255).
- `clock` in 1: single pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `em_mem_read` in 1: load in the MEM stage.
- `em_mem_write` in 1: store in the MEM stage.
- `em_mem_byte` in 1: byte access.
- `em_mem_half` in 1: halfword access. If neither `em_mem_byte` nor `em_mem_half` is set, the access is a word; byte wins if both are set.
- `em_mem_signed` in 1: sign-extend a byte or halfword load.
- `em_reg_write` in 1: instruction writes the register file.
- `em_mem_to_reg` in 1: writeback selects memory data.
- `em_alu_result` in 32: effective address, or the ALU result for non-memory instructions.
- `em_store_data` in 32: rt value for stores.
- `em_rt_rd` in 5: destination register.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write strobe.
- `dmem_addr` out 30: word address, equal to `em_alu_result[31:2]`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: store data, replicated across lanes.
- `dmem_rdata` in 32: read data, valid while `dmem_ready` is 1.
- `dmem_ready` in 1: access complete this cycle.
- `me_reg_write`, `me_mem_to_reg` out 1 each: to MEM/WB.
- `me_mem_read_data` out 32: aligned and extended load data.
- `me_alu_result` out 32: pass-through of `em_alu_result`.
- `me_rt_rd` out 5: pass-through of `em_rt_rd`.
- `me_stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `me_addr_error` out 1: misaligned access this cycle.
- `me_bus_error` out 1: timeout this cycle.
- `me_fault_addr` out 32: address of the last faulting access; registered.

## Operation
- **Access definition:** access = `em_mem_read | em_mem_write`. If both are set, the access is a store; the read is ignored.
- **Misalignment:** an access is misaligned when it is a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0. On a misaligned access:
  - no request is issued and `me_stall`=0;
  - `me_addr_error`=1, `me_reg_write`=0 and `me_mem_to_reg`=0;
  - `me_fault_addr` is loaded with `em_alu_result`.
- **Byte lanes:** lanes are little-endian; lane k is `dmem_rdata[8k+7:8k]`.
  - Byte access: `dmem_be`=1<<addr[1:0], and `dmem_wdata` is the store byte replicated four times.
  - Halfword access: `dmem_be`=0011 when addr[1]=0, else 1100; `dmem_wdata` is the store halfword replicated twice.
  - Word access: `dmem_be`=1111.
- **Load extraction:** the selected lane(s) are placed at bit 0 of `me_mem_read_data`. They are zero-extended, or sign-extended when `em_mem_signed`=1. A word load passes through unchanged.
- **FSM states:** IDLE and WAIT, plus a wait counter `wcnt` (8 bits).
  - IDLE, no access: pass-through with `me_stall`=0 and `dmem_req`=0.
  - IDLE, aligned access: `dmem_req`=1 combinationally.
    - If `dmem_ready`=1 in the same cycle, the access completes (zero-wait).
    - Otherwise `me_stall`=1, the outputs are a bubble, the FSM moves to WAIT and `wcnt` is set to 1.
  - WAIT: `dmem_req` and the other `dmem_*` outputs are held (the inputs are frozen by the stall).
    - If `dmem_ready`=1: the access completes, `me_stall`=0 and the FSM returns to IDLE.
    - Else if `wcnt`=`TIMEOUT_CYCLES`-1: `dmem_req`=0, `me_bus_error`=1, bubble, `me_stall`=0, `me_fault_addr` is loaded, and the FSM returns to IDLE.
    - Else `wcnt` increments and `me_stall` stays 1.
- **Completion:** the outputs are the `em_*` pass-through values, with `me_mem_read_data` taken from `dmem_rdata`.
- **Bubble:** `me_reg_write`=0 and `me_mem_to_reg`=0; the other outputs still pass through.
- **Ignored ready:** `dmem_ready` in IDLE with no request (for example a late response after a timeout) is ignored.

## Timing
- **Reset values:** FSM=IDLE, `wcnt`=0, `me_fault_addr`=0. All other outputs are combinational. During reset `dmem_req`=0, `me_stall`=0, `me_reg_write`=0, and both error outputs are 0.
- **Latency:** zero-wait memory adds 0 cycles. A response after N wait cycles adds N stall cycles.
- **Timeout:** the longest stall is `TIMEOUT_CYCLES`-1 cycles. The error is flagged in the cycle that releases the stall.
- **Pulse width:** `me_addr_error` and `me_bus_error` are single-cycle, coincident with the faulting instruction leaving the stage.
- **Reset during WAIT:** the FSM returns to IDLE immediately and `dmem_req` drops asynchronously. The partial store is not retried.
- **Ready on the final WAIT cycle:** if `dmem_ready` arrives in the same cycle that `wcnt` reaches the limit, completion wins and no bus error is raised.

## Test plan
- **Zero-wait byte load:** addr 0x1003, `em_mem_signed`=1, `dmem_rdata`=0x80xxxxxx, ready immediately → `me_mem_read_data`=0xFFFFFF80, `me_stall` never 1.
- **Halfword store:** addr 0x2002, data 0x0000BEEF → `dmem_be`=1100, `dmem_wdata`=0xBEEFBEEF, `dmem_we`=1, `dmem_addr`=0x800.
- **Word load, 3-cycle ready delay:** `me_stall` is high for exactly 3 cycles with bubbles, then completes; the MEM/WB stage latches `me_reg_write`=1 once.
- **Misaligned word:** addr 0x0000_0006 → `dmem_req`=0, `me_addr_error` pulses, `me_fault_addr`=0x6, no register write.
- **Timeout, `TIMEOUT_CYCLES`=4, ready never asserted:** stall for 3 cycles, `me_bus_error` pulses on the 4th cycle, FSM back to IDLE. A late ready is then ignored.
- **Reset mid-WAIT:** assert reset in WAIT → `dmem_req`=0 and `me_stall`=0 immediately, `wcnt`=0. The next access starts cleanly.

Source files
------------

// File: rtl/mem_access_stage.sv
// MIPS32 MEM stage: drives a handshaked data memory for byte/half/word loads and stores,
// stalls the pipeline while memory is slow and hands a result or bubble to MEM/WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        em_mem_read,
    input  logic        em_mem_write,
    input  logic        em_mem_byte,
    input  logic        em_mem_half,
    input  logic        em_mem_signed,
    input  logic        em_reg_write,
    input  logic        em_mem_to_reg,
    input  logic [31:0] em_alu_result,
    input  logic [31:0] em_store_data,
    input  logic [4:0]  em_rt_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        me_reg_write,
    output logic        me_mem_to_reg,
    output logic [31:0] me_mem_read_data,
    output logic [31:0] me_alu_result,
    output logic [4:0]  me_rt_rd,
    output logic        me_stall,
    output logic        me_addr_error,
    output logic        me_bus_error,
    output logic [31:0] me_fault_addr
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic        is_byte, is_half, is_word;
    logic        access, misaligned, bubble;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign is_byte    = em_mem_byte;
    assign is_half    = ~em_mem_byte & em_mem_half;
    assign is_word    = ~em_mem_byte & ~em_mem_half;
    assign access     = em_mem_read | em_mem_write;
    assign misaligned = access & ((is_half & em_alu_result[0]) |
                                  (is_word & (em_alu_result[1:0] != 2'b00)));

    assign dmem_addr     = em_alu_result[31:2];
    assign dmem_we       = dmem_req & em_mem_write;
    assign me_alu_result = em_alu_result;
    assign me_rt_rd      = em_rt_rd;
    assign me_fault_addr = fault_addr_q;
    assign me_reg_write  = em_reg_write & ~bubble;
    assign me_mem_to_reg = em_mem_to_reg & ~bubble;

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = em_store_data;
        if (is_byte) begin
            dmem_be    = 4'b0001 << em_alu_result[1:0];
            dmem_wdata = {4{em_store_data[7:0]}};
        end else if (is_half) begin
            dmem_be    = em_alu_result[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{em_store_data[15:0]}};
        end
    end

    // Little-endian lane select, then zero/sign extension to 32 bits.
    always_comb begin
        case (em_alu_result[1:0])
            2'd0:    load_byte = dmem_rdata[7:0];
            2'd1:    load_byte = dmem_rdata[15:8];
            2'd2:    load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = em_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_byte) begin
            me_mem_read_data = {{24{em_mem_signed & load_byte[7]}}, load_byte};
        end else if (is_half) begin
            me_mem_read_data = {{16{em_mem_signed & load_half[15]}}, load_half};
        end else begin
            me_mem_read_data = dmem_rdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        fault_addr_d  = fault_addr_q;
        dmem_req      = 1'b0;
        me_stall      = 1'b0;
        bubble        = 1'b0;
        me_addr_error = 1'b0;
        me_bus_error  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        me_addr_error = 1'b1;
                        bubble        = 1'b1;
                        fault_addr_d  = em_alu_result;
                    end else begin
                        dmem_req = 1'b1;
                        if (!dmem_ready) begin
                            me_stall = 1'b1;
                            bubble   = 1'b1;
                            state_d  = S_WAIT;
                            wcnt_d   = 8'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = S_IDLE;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q == WCNT_LAST) begin
                    dmem_req     = 1'b0;
                    me_bus_error = 1'b1;
                    bubble       = 1'b1;
                    fault_addr_d = em_alu_result;
                    state_d      = S_IDLE;
                    wcnt_d       = 8'd0;
                end else begin
                    wcnt_d   = wcnt_q + 8'd1;
                    me_stall = 1'b1;
                    bubble   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Reset also silences the combinational request/stall path, not just the state.
        if (reset) begin
            dmem_req      = 1'b0;
            me_stall      = 1'b0;
            bubble        = 1'b1;
            me_addr_error = 1'b0;
            me_bus_error  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wcnt_q       <= 8'd0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            fault_addr_q <= fault_addr_d;
        end
    end

endmodule
